// File: rtl/segway_pkg.sv
// Shared types and constants for the SegwayMath power-up / soft-start sequencer.
package segway_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } pwr_state_t;

    localparam logic [7:0] SS_MAX = 8'hFF;

endpackage

// File: rtl/segway_pwr_seq_ss_prescaler.sv
// Free-running soft-start prescaler: counts while enabled, ticks on the all-ones count.
module ss_prescaler #(
    parameter int SS_PRESCALE_W = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [SS_PRESCALE_W-1:0] cnt_q;
    logic [SS_PRESCALE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + SS_PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick coincides with the wrap back to zero.
    assign tick = en && (cnt_q == '1);

endmodule

// File: rtl/segway_pwr_seq.sv
// Power-up, soft-start ramp and over-speed shutdown sequencer feeding SegwayMath.
module segway_pwr_seq
    import segway_pkg::*;
#(
    parameter int SS_PRESCALE_W = 9,
    parameter int FAST_LIMIT    = 4,
    parameter int FAST_CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_req,
    input  logic       en_steer_req,
    input  logic       pid_vld,
    input  logic       too_fast,
    output logic       pwr_up,
    output logic [7:0] ss_tmr,
    output logic       en_steer,
    output logic       ramp_done,
    output logic       fault
);

    localparam logic [FAST_CNT_W-1:0] FAST_LIMIT_C = FAST_CNT_W'(FAST_LIMIT);

    pwr_state_t            state_q, state_d;
    logic [7:0]            ss_tmr_q, ss_tmr_d;
    logic [FAST_CNT_W-1:0] fast_cnt_q, fast_cnt_d, fast_inc;
    logic                  pwr_up_q, pwr_up_d;
    logic                  en_steer_q, en_steer_d;
    logic                  ramp_done_q, ramp_done_d;
    logic                  fault_q, fault_d;
    logic                  trip;
    logic                  ss_tick;

    ss_prescaler #(
        .SS_PRESCALE_W(SS_PRESCALE_W)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (state_q != RAMP),
        .en  (state_q == RAMP),
        .tick(ss_tick)
    );

    always_comb begin
        state_d    = state_q;
        ss_tmr_d   = ss_tmr_q;
        fast_cnt_d = fast_cnt_q;
        en_steer_d = 1'b0;
        fast_inc   = fast_cnt_q + FAST_CNT_W'(1);
        trip       = pid_vld && too_fast && (fast_inc == FAST_LIMIT_C);

        case (state_q)
            OFF: begin
                fast_cnt_d = '0;
                if (pwr_req) begin
                    state_d = RAMP;
                end
            end
            RAMP, RUN: begin
                // Trip outranks a simultaneous power drop so fault is always visible.
                if (trip) begin
                    state_d    = FAULT;
                    fast_cnt_d = '0;
                end else if (!pwr_req) begin
                    state_d    = OFF;
                    fast_cnt_d = '0;
                end else begin
                    if (pid_vld) begin
                        fast_cnt_d = too_fast ? fast_inc : '0;
                    end
                    if (state_q == RAMP) begin
                        if (ss_tick && (ss_tmr_q != SS_MAX)) begin
                            ss_tmr_d = ss_tmr_q + 8'd1;
                            if (ss_tmr_q == SS_MAX - 8'd1) begin
                                state_d = RUN;
                            end
                        end
                    end else begin
                        en_steer_d = en_steer_req;
                    end
                end
            end
            FAULT: begin
                fast_cnt_d = '0;
                if (!pwr_req) begin
                    state_d = OFF;
                end
            end
            default: begin
                state_d    = OFF;
                fast_cnt_d = '0;
            end
        endcase

        if ((state_d == OFF) || (state_d == FAULT)) begin
            ss_tmr_d = '0;
        end else if (state_d == RUN) begin
            ss_tmr_d = SS_MAX;
        end

        pwr_up_d    = (state_d == RAMP) || (state_d == RUN);
        ramp_done_d = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OFF;
            ss_tmr_q    <= '0;
            fast_cnt_q  <= '0;
            pwr_up_q    <= 1'b0;
            en_steer_q  <= 1'b0;
            ramp_done_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_tmr_q    <= ss_tmr_d;
            fast_cnt_q  <= fast_cnt_d;
            pwr_up_q    <= pwr_up_d;
            en_steer_q  <= en_steer_d;
            ramp_done_q <= ramp_done_d;
            fault_q     <= fault_d;
        end
    end

    assign pwr_up    = pwr_up_q;
    assign ss_tmr    = ss_tmr_q;
    assign en_steer  = en_steer_q;
    assign ramp_done = ramp_done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_segway_pwr_seq.sv
// Directed bench for segway_pwr_seq with a fast (4-clock) soft-start prescaler.
module tb_segway_pwr_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_req;
    logic       en_steer_req;
    logic       pid_vld;
    logic       too_fast;
    logic       pwr_up;
    logic [7:0] ss_tmr;
    logic       en_steer;
    logic       ramp_done;
    logic       fault;

    int n_cmp  = 0;
    int n_fail = 0;

    segway_pwr_seq #(
        .SS_PRESCALE_W(2),
        .FAST_LIMIT   (4),
        .FAST_CNT_W   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwr_req     (pwr_req),
        .en_steer_req(en_steer_req),
        .pid_vld     (pid_vld),
        .too_fast    (too_fast),
        .pwr_up      (pwr_up),
        .ss_tmr      (ss_tmr),
        .en_steer    (en_steer),
        .ramp_done   (ramp_done),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic p, input logic [7:0] s,
                             input logic e, input logic r, input logic f);
        check({tag, ".pwr_up"},    {7'd0, pwr_up},    {7'd0, p});
        check({tag, ".ss_tmr"},    ss_tmr,            s);
        check({tag, ".en_steer"},  {7'd0, en_steer},  {7'd0, e});
        check({tag, ".ramp_done"}, {7'd0, ramp_done}, {7'd0, r});
        check({tag, ".fault"},     {7'd0, fault},     {7'd0, f});
    endtask

    // One qualified too_fast sample followed by two idle cycles.
    task automatic pulse(input logic tf);
        pid_vld  = 1'b1;
        too_fast = tf;
        step(1);
        pid_vld  = 1'b0;
        too_fast = 1'b0;
        step(2);
    endtask

    initial begin
        rst          = 1'b1;
        pwr_req      = 1'b0;
        en_steer_req = 1'b0;
        pid_vld      = 1'b0;
        too_fast     = 1'b0;
        step(2);
        check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Ramp timing: 4 clocks per ss_tmr step, 1020 clocks to 0xFF.
        pwr_req      = 1'b1;
        en_steer_req = 1'b1;
        step(1);
        check_all("ramp_entry", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(3);
        check("ramp_e3", ss_tmr, 8'h00);
        step(1);
        check("ramp_e4", ss_tmr, 8'h01);
        step(3);
        check("ramp_e7", ss_tmr, 8'h01);
        step(1);
        check("ramp_e8", ss_tmr, 8'h02);
        step(1011);
        check_all("ramp_e1019", 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        step(1);
        check_all("run_entry", 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        step(1);
        check("steer_on", {7'd0, en_steer}, 8'd1);

        // Steer follows the request with one cycle of latency.
        en_steer_req = 1'b0;
        step(1);
        check("steer_off", {7'd0, en_steer}, 8'd0);
        en_steer_req = 1'b1;
        step(1);
        check("steer_back", {7'd0, en_steer}, 8'd1);

        // 3 hits, 1 miss, 3 hits must not trip.
        pulse(1'b1); pulse(1'b1); pulse(1'b1);
        pulse(1'b0);
        pulse(1'b1); pulse(1'b1); pulse(1'b1);
        check_all("no_trip_3_1_3", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);

        // Clear the count, then the 4th consecutive hit trips on its own edge.
        pulse(1'b0);
        pulse(1'b1); pulse(1'b1); pulse(1'b1);
        check("pre_trip_fault", {7'd0, fault}, 8'd0);
        pid_vld  = 1'b1;
        too_fast = 1'b1;
        step(1);
        pid_vld  = 1'b0;
        too_fast = 1'b0;
        check_all("trip", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Fault latches while pwr_req stays high.
        step(100);
        check_all("fault_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        pwr_req = 1'b0;
        step(1);
        check_all("fault_exit", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Fresh ramp after the fault clears.
        pwr_req = 1'b1;
        step(1);
        check_all("reramp_entry", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(4);
        check("reramp_e4", ss_tmr, 8'h01);

        // Power drop at ss_tmr=0x40 (256 clocks into the ramp).
        step(252);
        check("ramp_0x40", ss_tmr, 8'h40);
        pwr_req = 1'b0;
        step(1);
        check_all("drop_mid_ramp", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pwr_req = 1'b1;
        step(1);
        check_all("restart_entry", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(4);
        check("restart_e4", ss_tmr, 8'h01);
        step(1016);
        check_all("restart_run", 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);

        // Reset mid-run clears everything; held pwr_req then restarts the ramp.
        step(3);
        check("run_steer", {7'd0, en_steer}, 8'd1);
        rst = 1'b1;
        step(1);
        check_all("rst_mid_run", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);
        check_all("post_rst_ramp", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1020);
        check("post_rst_run", {7'd0, ramp_done}, 8'd1);

        // Trip coinciding with power drop: one cycle of fault, then off.
        pulse(1'b1); pulse(1'b1); pulse(1'b1);
        pid_vld  = 1'b1;
        too_fast = 1'b1;
        pwr_req  = 1'b0;
        step(1);
        pid_vld  = 1'b0;
        too_fast = 1'b0;
        check_all("coincide_fault", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1);
        check_all("coincide_off", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(3);
        check_all("stay_off", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
